pc_fetch_ctrl: RTL and testbench

- Sequences the program counter register and the instruction-memory fetch handshake for the MIPS core.
- Chooses the next PC from four sources: sequential, branch, jump, or jump-register.
- Holds the PC during stalls and while a fetch is outstanding.
- Records a redirect that arrives during a fetch, squashes the wrong-path instruction, and steers misaligned targets to the exception vector.

---
 rtl/pc_fetch_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Program-counter sequencer and instruction-fetch handshake for the MIPS core.
//   It picks the next PC from four sources: sequential, branch, jump or jump-register.
//   It holds the PC during stalls and while a fetch is outstanding.
//   A redirect that arrives while a fetch is in flight is latched.
//   The wrong-path instruction is squashed when that fetch completes.
//   Misaligned redirect targets are replaced by the exception vector.
//   All state changes on the falling edge of clk.
//
// Ports
//   clk            in   system clock (state updates on negedge)
//   reset          in   asynchronous active-low reset
//   stall          in   pipeline hold, blocks issue of a new fetch
//   branch_taken   in   branch resolved taken; branch_target is its destination
//   jump           in   j/jal; jump_target is its destination
//   jr             in   jr/jalr; jr_target is its destination
//   imem_ack       in   instruction memory completes the outstanding fetch
//   pc             out  current fetch address
//   imem_req       out  fetch request, high until imem_ack
//   inst_valid     out  one-cycle pulse when the completed fetch is on the correct path
//   addr_err       out  one-cycle pulse when a misaligned target is replaced by EXC_PC
//   redirect_pend  out  redirect latched, waiting for the in-flight fetch to finish
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0040_0020,
   parameter logic [31:0] EXC_PC   = 32'h8000_0180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        jr,
   input  logic [31:0] jr_target,
   input  logic        imem_ack,
   output logic [31:0] pc,
   output logic        imem_req,
   output logic        inst_valid,
   output logic        addr_err,
   output logic        redirect_pend
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        imem_req_q, imem_req_d;
   logic        inst_valid_q, inst_valid_d;
   logic        addr_err_q, addr_err_d;
   logic        pend_q, pend_d;
   logic [31:0] pend_tgt_q, pend_tgt_d;

   logic        redir_s;
   logic [31:0] raw_tgt_s;
   logic        misalign_s;
   logic [31:0] redir_tgt_s;

   // Redirect source select (jr > jump > branch) and misalignment substitution
   always_comb begin
      redir_s   = jr | jump | branch_taken;
      raw_tgt_s = 32'h0000_0000;
      if (jr) begin
         raw_tgt_s = jr_target;
      end else if (jump) begin
         raw_tgt_s = jump_target;
      end else if (branch_taken) begin
         raw_tgt_s = branch_target;
      end else begin
         raw_tgt_s = 32'h0000_0000;
      end
      misalign_s  = redir_s && (raw_tgt_s[1:0] != 2'b00);
      redir_tgt_s = misalign_s ? EXC_PC : raw_tgt_s;
   end

   // Next-state, next-PC and output pulse computation
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pend_d       = pend_q;
      pend_tgt_d   = pend_tgt_q;
      inst_valid_d = 1'b0;
      addr_err_d   = 1'b0;

      case (state_q)
         ST_BOOT: begin
            // imem_ack here is ignored: any fetch pending before reset was abandoned
            state_d = ST_FETCH;
            pc_d    = RESET_PC;
         end
         ST_FETCH: begin
            if (imem_ack) begin
               if (redir_s) begin
                  // A same-edge redirect overrides anything already latched
                  pc_d       = redir_tgt_s;
                  addr_err_d = misalign_s;
                  pend_d     = 1'b0;
               end else if (pend_q) begin
                  pc_d   = pend_tgt_q;
                  pend_d = 1'b0;
               end else begin
                  inst_valid_d = 1'b1;
                  pc_d         = pc_q + 32'd4;
               end
               state_d = stall ? ST_HOLD : ST_FETCH;
            end else if (redir_s) begin
               // Fetch still in flight: remember the target; PC stays on the current fetch
               pend_d     = 1'b1;
               pend_tgt_d = redir_tgt_s;
               addr_err_d = misalign_s;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_HOLD: begin
            // No request is outstanding, so a redirect can update the PC directly
            if (redir_s) begin
               pc_d       = redir_tgt_s;
               addr_err_d = misalign_s;
            end else begin
               pc_d = pc_q;
            end
            state_d = stall ? ST_HOLD : ST_FETCH;
         end
         default: begin
            state_d    = ST_BOOT;
            pc_d       = RESET_PC;
            pend_d     = 1'b0;
            pend_tgt_d = 32'h0000_0000;
         end
      endcase

      imem_req_d = (state_d == ST_FETCH);
   end

   // State and registered-output flops, updated on the falling edge
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_BOOT;
         pc_q         <= RESET_PC;
         imem_req_q   <= 1'b0;
         inst_valid_q <= 1'b0;
         addr_err_q   <= 1'b0;
         pend_q       <= 1'b0;
         pend_tgt_q   <= 32'h0000_0000;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         imem_req_q   <= imem_req_d;
         inst_valid_q <= inst_valid_d;
         addr_err_q   <= addr_err_d;
         pend_q       <= pend_d;
         pend_tgt_q   <= pend_tgt_d;
      end
   end

   assign pc            = pc_q;
   assign imem_req      = imem_req_q;
   assign inst_valid    = inst_valid_q;
   assign addr_err      = addr_err_q;
   assign redirect_pend = pend_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl. Inputs are driven 1 time unit after a falling edge.
// Outputs are sampled 1 time unit after the next falling edge.
module tb_pc_fetch_ctrl;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        jr;
   logic [31:0] jr_target;
   logic        imem_ack;
   logic [31:0] pc;
   logic        imem_req;
   logic        inst_valid;
   logic        addr_err;
   logic        redirect_pend;

   int checks   = 0;
   int failures = 0;

   pc_fetch_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .jr            (jr),
      .jr_target     (jr_target),
      .imem_ack      (imem_ack),
      .pc            (pc),
      .imem_req      (imem_req),
      .inst_valid    (inst_valid),
      .addr_err      (addr_err),
      .redirect_pend (redirect_pend)
   );

   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clr_redir();
      branch_taken = 1'b0;
      jump         = 1'b0;
      jr           = 1'b0;
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; imem_ack = 1'b0;
      branch_taken = 1'b0; branch_target = 32'h0;
      jump = 1'b0; jump_target = 32'h0;
      jr = 1'b0; jr_target = 32'h0;

      // Reset state
      step(); step();
      chk("rst_pc", pc, 32'h0040_0020);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_iv", {31'd0, inst_valid}, 32'd0);
      chk("rst_ae", {31'd0, addr_err}, 32'd0);
      chk("rst_rp", {31'd0, redirect_pend}, 32'd0);

      // 1: release with ack held high every edge
      reset = 1'b1; imem_ack = 1'b1;
      step();
      chk("boot_pc", pc, 32'h0040_0020);
      chk("boot_req", {31'd0, imem_req}, 32'd1);
      chk("boot_iv", {31'd0, inst_valid}, 32'd0);
      step();
      chk("seq1_pc", pc, 32'h0040_0024);
      chk("seq1_iv", {31'd0, inst_valid}, 32'd1);
      chk("seq1_req", {31'd0, imem_req}, 32'd1);

      // 2: branch during fetch, ack two edges later
      imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h0040_0100;
      step();
      chk("br_rp1", {31'd0, redirect_pend}, 32'd1);
      chk("br_pc1", pc, 32'h0040_0024);
      chk("br_iv1", {31'd0, inst_valid}, 32'd0);
      clr_redir();
      step();
      chk("br_rp2", {31'd0, redirect_pend}, 32'd1);
      chk("br_pc2", pc, 32'h0040_0024);
      imem_ack = 1'b1;
      step();
      chk("br_ack_iv", {31'd0, inst_valid}, 32'd0);
      chk("br_ack_pc", pc, 32'h0040_0100);
      chk("br_ack_rp", {31'd0, redirect_pend}, 32'd0);
      step();
      chk("br_next_iv", {31'd0, inst_valid}, 32'd1);
      chk("br_next_pc", pc, 32'h0040_0104);

      // 3: jr/jump/branch together with ack, jr wins and the fetch is squashed
      jr = 1'b1; jr_target = 32'h0040_0200;
      jump = 1'b1; jump_target = 32'h0040_0300;
      branch_taken = 1'b1; branch_target = 32'h0040_0100;
      step();
      chk("pri_pc", pc, 32'h0040_0200);
      chk("pri_iv", {31'd0, inst_valid}, 32'd0);
      chk("pri_ae", {31'd0, addr_err}, 32'd0);
      clr_redir();

      // 4: misaligned jump target goes to the exception vector
      jump = 1'b1; jump_target = 32'h0040_0302;
      step();
      chk("mis_pc", pc, 32'h8000_0180);
      chk("mis_ae", {31'd0, addr_err}, 32'd1);
      chk("mis_iv", {31'd0, inst_valid}, 32'd0);
      clr_redir(); imem_ack = 1'b0;
      step();
      chk("mis_ae_once", {31'd0, addr_err}, 32'd0);
      chk("mis_pc_hold", pc, 32'h8000_0180);
      imem_ack = 1'b1;
      step();
      chk("exc_seq_pc", pc, 32'h8000_0184);
      chk("exc_seq_iv", {31'd0, inst_valid}, 32'd1);

      // 5: stall across an ack moves to HOLD
      jump = 1'b1; jump_target = 32'h0040_0030;
      step();
      chk("to30_pc", pc, 32'h0040_0030);
      clr_redir(); stall = 1'b1;
      step();
      chk("st_pc", pc, 32'h0040_0034);
      chk("st_iv", {31'd0, inst_valid}, 32'd1);
      chk("st_req", {31'd0, imem_req}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_pc", pc, 32'h0040_0034);
         chk("hold_req", {31'd0, imem_req}, 32'd0);
         chk("hold_iv", {31'd0, inst_valid}, 32'd0);
      end
      stall = 1'b0; imem_ack = 1'b0;
      step();
      chk("resume_req", {31'd0, imem_req}, 32'd1);
      chk("resume_pc", pc, 32'h0040_0034);
      // Back into HOLD, then redirect while held
      stall = 1'b1; imem_ack = 1'b1;
      step();
      chk("h2_pc", pc, 32'h0040_0038);
      chk("h2_req", {31'd0, imem_req}, 32'd0);
      imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h0040_0500;
      step();
      chk("hredir_pc", pc, 32'h0040_0500);
      chk("hredir_req", {31'd0, imem_req}, 32'd0);
      chk("hredir_iv", {31'd0, inst_valid}, 32'd0);
      clr_redir(); stall = 1'b0;
      step();
      chk("hres_req", {31'd0, imem_req}, 32'd1);
      chk("hres_pc", pc, 32'h0040_0500);
      // Redirect under stall in FETCH is still latched
      stall = 1'b1; jr = 1'b1; jr_target = 32'h0040_0600;
      step();
      chk("sl_rp", {31'd0, redirect_pend}, 32'd1);
      chk("sl_req", {31'd0, imem_req}, 32'd1);
      clr_redir(); imem_ack = 1'b1;
      step();
      chk("sl_pc", pc, 32'h0040_0600);
      chk("sl_iv", {31'd0, inst_valid}, 32'd0);
      chk("sl_rp0", {31'd0, redirect_pend}, 32'd0);
      chk("sl_req0", {31'd0, imem_req}, 32'd0);
      stall = 1'b0; imem_ack = 1'b0;
      step();
      chk("sl_res_req", {31'd0, imem_req}, 32'd1);

      // 6: async reset mid-fetch with a pending redirect
      branch_taken = 1'b1; branch_target = 32'h0040_0700;
      step();
      chk("pre_rst_rp", {31'd0, redirect_pend}, 32'd1);
      clr_redir();
      #2 reset = 1'b0;
      #1;
      chk("arst_pc", pc, 32'h0040_0020);
      chk("arst_rp", {31'd0, redirect_pend}, 32'd0);
      chk("arst_req", {31'd0, imem_req}, 32'd0);
      imem_ack = 1'b1;
      step();
      reset = 1'b1;
      step();
      chk("late_ack_pc", pc, 32'h0040_0020);
      chk("late_ack_iv", {31'd0, inst_valid}, 32'd0);
      chk("late_ack_rp", {31'd0, redirect_pend}, 32'd0);
      imem_ack = 1'b0;
      step();
      chk("post_rst_pc", pc, 32'h0040_0020);
      // PC wrap at the top of the address space
      jump = 1'b1; jump_target = 32'hFFFF_FFFC; imem_ack = 1'b1;
      step();
      chk("wrap_set_pc", pc, 32'hFFFF_FFFC);
      clr_redir();
      step();
      chk("wrap_pc", pc, 32'h0000_0000);
      chk("wrap_iv", {31'd0, inst_valid}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
